// File: rtl/pong_pkg.sv
// Shared pong constants and the LED matrix scan state encoding.
// Sizes here match the screen logic's frame buffer layout.
package pong_pkg;

  localparam int unsigned PONG_ROWS        = 8;
  localparam int unsigned PONG_COLS        = 8;
  localparam int unsigned PONG_DWELL_WIDTH = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_COL,
    ST_SHIFT_ROW,
    ST_LATCH,
    ST_DISPLAY
  } led_state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_shift_out.sv
// Generic MSB-first serializer; each bit takes two clocks:
// data set up with sclk low, then sclk high with data held.
module matrix_shift_out
  import pong_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] data,
  output logic         busy,
  output logic         sdo,
  output logic         sclk,
  output logic         done
);

  localparam int unsigned CW = cnt_width(N);

  logic [N-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          busy_q, busy_d;
  logic          last;

  assign last = (cnt_q == CW'(N - 1));
  assign busy = busy_q;
  assign sdo  = shreg_q[N-1];
  assign sclk = phase_q;
  assign done = busy_q & phase_q & last;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    busy_d  = busy_q;
    if (start) begin
      shreg_d = data;
      cnt_d   = '0;
      phase_d = 1'b0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      phase_d = ~phase_q;
      if (phase_q) begin
        shreg_d = {shreg_q[N-2:0], 1'b0};
        if (last) begin
          busy_d = 1'b0;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: rtl/led_matrix_driver.sv
// Row-multiplexed LED matrix scanner: snapshots the frame at row 0,
// shifts column and walking-one row data, latches, then displays.
module led_matrix_driver
  import pong_pkg::*;
#(
  parameter int unsigned ROWS        = PONG_ROWS,
  parameter int unsigned COLS        = PONG_COLS,
  parameter int unsigned DWELL_WIDTH = PONG_DWELL_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [ROWS*COLS-1:0] pixels,
  output logic                 rclk,
  output logic                 rsdi,
  output logic                 csdi,
  output logic                 cclk,
  output logic                 le,
  output logic                 oeb,
  output logic                 frame_start
);

  localparam int unsigned RW = cnt_width(ROWS);

  led_state_t             state_q, state_d;
  logic [RW-1:0]          row_q, row_d;
  logic [ROWS*COLS-1:0]   snap_q, snap_d;
  logic                   rph_q, rph_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;

  logic            row_zero, row_last, dwell_last;
  logic            col_start, col_busy, col_sdo, col_sclk, col_done;
  logic [COLS-1:0] col_data;

  assign row_zero   = (row_q == '0);
  assign row_last   = (row_q == RW'(ROWS - 1));
  assign dwell_last = &dwell_q;
  assign col_start  = (state_q == ST_LOAD);

  // Row 0 reads live pixels in the same cycle the snapshot is taken.
  assign col_data = row_zero ? pixels[COLS-1:0]
                             : snap_q[row_q*COLS +: COLS];

  matrix_shift_out #(
    .N(COLS)
  ) u_col (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (col_start),
    .data   (col_data),
    .busy   (col_busy),
    .sdo    (col_sdo),
    .sclk   (col_sclk),
    .done   (col_done)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    snap_d  = snap_q;
    rph_d   = rph_q;
    dwell_d = dwell_q;
    unique case (state_q)
      ST_IDLE: begin
        row_d = '0;
        if (enable) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (row_zero) snap_d = pixels;
        state_d = ST_SHIFT_COL;
      end
      ST_SHIFT_COL: begin
        if (col_done) state_d = ST_SHIFT_ROW;
      end
      ST_SHIFT_ROW: begin
        rph_d = ~rph_q;
        if (rph_q) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        dwell_d = '0;
        state_d = ST_DISPLAY;
      end
      ST_DISPLAY: begin
        dwell_d = dwell_last ? '0 : dwell_q + DWELL_WIDTH'(1);
        if (dwell_last) begin
          if (enable) begin
            row_d   = row_last ? '0 : row_q + RW'(1);
            state_d = ST_LOAD;
          end else begin
            row_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      snap_q  <= '0;
      rph_q   <= 1'b0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      snap_q  <= snap_d;
      rph_q   <= rph_d;
      dwell_q <= dwell_d;
    end
  end

  // Outputs decode straight from reset-cleared flops.
  always_comb begin
    rclk        = (state_q == ST_SHIFT_ROW) & rph_q;
    rsdi        = (state_q == ST_SHIFT_ROW) & row_zero;
    csdi        = col_busy & col_sdo;
    cclk        = col_busy & col_sclk;
    le          = (state_q == ST_LATCH);
    oeb         = (state_q != ST_DISPLAY);
    frame_start = (state_q == ST_LOAD) & row_zero;
  end

endmodule

// File: tb/tb_led_matrix_driver.sv
// Bench for led_matrix_driver with an external shift-register model
// of the matrix (column/row registers, latches and lit-pixel map).
module tb_led_matrix_driver;

  localparam int R  = 8;
  localparam int C  = 8;
  localparam int DW = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [63:0] pixels = '0;
  logic        rclk, rsdi, csdi, cclk, le, oeb, frame_start;

  always #5 clk = ~clk;

  led_matrix_driver #(
    .ROWS(R), .COLS(C), .DWELL_WIDTH(DW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pixels(pixels),
    .rclk(rclk), .rsdi(rsdi), .csdi(csdi), .cclk(cclk),
    .le(le), .oeb(oeb), .frame_start(frame_start)
  );

  typedef struct {
    logic [7:0] col;
    logic [7:0] row;
    logic       rs;
    int         cyc;
  } ev_t;

  typedef struct {
    logic [63:0] pix;
    logic [7:0]  r0;
    logic [7:0]  r3;
    logic [7:0]  r7;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // matrix model state
  int         cyc = 0;
  int         le_cnt = 0;
  int         fs_cnt = 0;
  int         fs_cyc = 0;
  int         oeb_cnt = 0;
  int         lit [64];
  ev_t        log_q [$];
  logic [7:0] csr, rsr, clat, rlat;
  logic       pc = 1'b0, pr = 1'b0, pcs = 1'b0, prs = 1'b0, rs_last = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      csr = '0; rsr = '0; clat = '0; rlat = '0;
      pc = 1'b0; pr = 1'b0; pcs = 1'b0; prs = 1'b0;
    end else begin
      if (cclk && !pc) begin
        chk("csdi_setup", csdi, pcs);
        csr = {csr[6:0], csdi};
      end
      if (rclk && !pr) begin
        chk("rsdi_setup", rsdi, prs);
        rsr = {rsr[6:0], rsdi};
        rs_last = rsdi;
      end
      if (le) begin
        chk("le_clocks_low", {cclk, rclk, oeb}, 3'b001);
        clat = csr;
        rlat = rsr;
        log_q.push_back('{col: csr, row: rsr, rs: rs_last, cyc: cyc});
        le_cnt++;
      end
      if (frame_start) begin
        fs_cnt++;
        fs_cyc = cyc;
      end
      if (!oeb) begin
        oeb_cnt++;
        if (cclk || rclk || csdi || rsdi)
          chk("quiet_in_display", {cclk, rclk, csdi, rsdi}, 4'b0);
        for (int r = 0; r < R; r++)
          for (int c = 0; c < C; c++)
            if (rlat[r] && clat[c]) lit[r*C+c]++;
      end
      pc = cclk; pr = rclk; pcs = csdi; prs = rsdi;
    end
  end

  task automatic clear_model();
    le_cnt = 0; fs_cnt = 0; oeb_cnt = 0;
    log_q.delete();
    for (int i = 0; i < 64; i++) lit[i] = 0;
  endtask

  task automatic do_reset();
    enable  = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    clear_model();
    reset_n = 1'b1;
  endtask

  task automatic wait_le(input int n, input int budget);
    int k = 0;
    while (le_cnt < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (le_cnt < n) begin
      checks++; errors++;
      $display("FAIL wait_le got %0d want %0d", le_cnt, n);
    end
  endtask

  vec_t vecs [4];

  initial begin
    logic [63:0] a, b;
    int k, t0, ob;

    vecs[0] = '{pix: 64'h0000_0000_2000_0000, r0: 8'h00, r3: 8'h20, r7: 8'h00};
    vecs[1] = '{pix: 64'hAA55_AA55_AA55_AA55, r0: 8'h55, r3: 8'hAA, r7: 8'hAA};
    vecs[2] = '{pix: 64'hFFFF_FFFF_FFFF_FFFF, r0: 8'hFF, r3: 8'hFF, r7: 8'hFF};
    vecs[3] = '{pix: 64'h0123_4567_89AB_CDEF, r0: 8'hEF, r3: 8'h89, r7: 8'h01};
    a = 64'hAA55_AA55_AA55_AA55;
    b = 64'h55AA_55AA_55AA_55AA;
    clear_model();

    // reset state with clock running
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {rclk, rsdi, csdi, cclk, le, oeb, frame_start},
        7'b0000010);
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    #1;
    chk("idle_no_le", le_cnt, 0);
    chk("idle_no_display", oeb_cnt, 0);
    chk("idle_no_frame", fs_cnt, 0);
    chk("idle_oeb", oeb, 1'b1);

    // one full frame per table entry
    for (int v = 0; v < 4; v++) begin
      int bad;
      do_reset();
      pixels = vecs[v].pix;
      enable = 1'b1;
      wait_le(8, 400);
      enable = 1'b0;
      repeat (30) @(negedge clk);
      #1;
      chk("frame_count", fs_cnt, 1);
      chk("idle_after_frame", oeb, 1'b1);
      if (log_q.size() >= 8) begin
        chk("load_to_le", log_q[0].cyc - fs_cyc, 19);
        chk("hand_r0", log_q[0].col, vecs[v].r0);
        chk("hand_r3", log_q[3].col, vecs[v].r3);
        chk("hand_r7", log_q[7].col, vecs[v].r7);
        for (int r = 0; r < 8; r++) begin
          chk("row_onehot", log_q[r].row, 64'(1) << r);
          chk("row_cols", log_q[r].col, vecs[v].pix[r*8 +: 8]);
          chk("rsdi_row0", log_q[r].rs, (r == 0));
          if (r > 0) chk("row_period", log_q[r].cyc - log_q[r-1].cyc, 24);
        end
      end
      bad = 0;
      for (int i = 0; i < 64; i++)
        if (lit[i] != (vecs[v].pix[i] ? 4 : 0)) bad++;
      chk("lit_map", bad, 0);
    end

    // pixels change while row 3 displays
    do_reset();
    pixels = a;
    enable = 1'b1;
    wait_le(4, 200);
    pixels = b;
    wait_le(16, 600);
    enable = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    chk("tear_frames", fs_cnt, 2);
    if (log_q.size() >= 16) begin
      chk("tear_new_r0", log_q[8].col, 8'hAA);
      for (int i = 0; i < 16; i++)
        chk("tear_rows", log_q[i].col,
            (i < 8) ? a[(i%8)*8 +: 8] : b[(i%8)*8 +: 8]);
    end

    // enable drops during row 2 column shift
    do_reset();
    pixels = vecs[3].pix;
    enable = 1'b1;
    wait_le(2, 200);
    k = 0;
    while (!cclk && k < 40) begin
      @(negedge clk); #1;
      k++;
    end
    chk("drop_saw_cclk", cclk, 1'b1);
    enable = 1'b0;
    ob = oeb_cnt;
    repeat (60) @(negedge clk);
    #1;
    chk("drop_le_count", le_cnt, 3);
    chk("drop_row2_dwell", oeb_cnt - ob, 4);
    chk("drop_idle_oeb", oeb, 1'b1);
    if (log_q.size() >= 3) chk("drop_row2", log_q[2].row, 8'h04);
    t0 = cyc;
    enable = 1'b1;
    wait_le(4, 200);
    chk("restart_frame", fs_cnt, 2);
    chk("restart_fs_delay", fs_cyc - t0, 1);
    if (log_q.size() >= 4) begin
      chk("restart_rs", log_q[3].rs, 1'b1);
      chk("restart_cols", log_q[3].col, 8'hEF);
    end
    enable = 1'b0;
    repeat (40) @(negedge clk);

    // asynchronous reset while displaying
    do_reset();
    pixels = a;
    enable = 1'b1;
    wait_le(3, 200);
    @(negedge clk); #1;
    chk("pre_reset_oeb", oeb, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {rclk, rsdi, csdi, cclk, le, oeb, frame_start}, 7'b0000010);
    repeat (2) @(negedge clk);
    #1;
    reset_n = 1'b1;
    wait_le(4, 200);
    chk("post_reset_frame", fs_cnt, 2);
    if (log_q.size() >= 4) begin
      chk("post_reset_row", log_q[3].row, 8'h01);
      chk("post_reset_cols", log_q[3].col, 8'h55);
    end
    enable = 1'b0;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
